// File: rtl/gpu_framebuffer_pkg.sv
// Shared framebuffer geometry, coordinate/address types and the raster address helper.
// The optional bounds-error flag in the top level is controlled by FB_BOUNDS_ERR_EN.
package gpu_defs;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 200;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int FB_ADDR_W = 16;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  typedef logic [X_W-1:0]       fb_x_t;
  typedef logic [Y_W-1:0]       fb_y_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  // Raster address y*width+x, truncated to the address width.
  function automatic fb_addr_t fb_addr(input fb_x_t x, input fb_y_t y,
                                       input int width = FB_WIDTH);
    return FB_ADDR_W'({{(32-Y_W){1'b0}}, y} * $unsigned(width)
                      + {{(32-X_W){1'b0}}, x});
  endfunction

endpackage

// File: rtl/gpu_framebuffer_if.sv
// Op-engine RAM port: pixel coordinates, read/write strobes and read data.
interface gpu_framebuffer_if;
  import gpu_defs::*;

  fb_x_t op_x;
  fb_y_t op_y;
  logic  op_ram_enable_read;
  logic  op_ram_enable_write;
  logic  op_ram_write_value;
  logic  op_ram_value;

  modport master (
    output op_x,
    output op_y,
    output op_ram_enable_read,
    output op_ram_enable_write,
    output op_ram_write_value,
    input  op_ram_value
  );

  modport slave (
    input  op_x,
    input  op_y,
    input  op_ram_enable_read,
    input  op_ram_enable_write,
    input  op_ram_write_value,
    output op_ram_value
  );

endinterface

// File: rtl/gpu_framebuffer_bitmem.sv
// 1-bit true dual-port RAM: port A read/write on the falling edge, port B read-only
// on the rising edge. Only the port A read register is reset; contents are not.
module fb_bitmem
  import gpu_defs::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = FB_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_en_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic          a_wdata_i,
  output logic          a_rdata_o,
  input  logic          b_en_i,
  input  logic [AW-1:0] b_addr_i,
  output logic          b_rdata_o
);

  logic mem_q [DEPTH];
  logic a_rdata_q;
  logic b_rdata_q;

  always_ff @(negedge clk) begin
    if (a_en_i && a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
  end

  // Separate process from the write, so a same-edge read returns the old contents.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= 1'b0;
    end else if (a_en_i) begin
      a_rdata_q <= mem_q[a_addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (b_en_i) begin
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/gpu_framebuffer.sv
// 1-bpp framebuffer: zero-wait op port on the falling edge plus raster scanout on
// the rising edge. FB_BOUNDS_ERR_EN enables the sticky out-of-range error flag.
module gpu_framebuffer
  import gpu_defs::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic              clk,
  input  logic              rst_n,
  gpu_framebuffer_if.slave  op,
  input  logic              scan_en,
  input  logic              scan_restart,
  output logic              scan_pixel,
  output logic              scan_valid,
  output logic              scan_frame_done,
  input  logic              err_clear,
  output logic              oob_error
);

  localparam fb_x_t X_LAST = X_W'(WIDTH - 1);
  localparam fb_y_t Y_LAST = Y_W'(HEIGHT - 1);

  logic     op_req;
  logic     op_in_range;
  fb_addr_t op_addr;
  logic     mem_a_rdata;
  logic     op_oob_rd_q;

  fb_x_t    scan_x_q, scan_x_d;
  fb_y_t    scan_y_q, scan_y_d;
  logic     scan_valid_q, scan_valid_d;
  logic     scan_done_q, scan_done_d;
  logic     scan_rd_en;
  fb_addr_t scan_addr;
  logic     mem_b_rdata;

  assign op_req      = op.op_ram_enable_read | op.op_ram_enable_write;
  assign op_in_range = (int'(op.op_x) < WIDTH) && (int'(op.op_y) < HEIGHT);
  assign op_addr     = fb_addr(op.op_x, op.op_y, WIDTH);

  assign scan_rd_en  = scan_en & ~scan_restart;
  assign scan_addr   = fb_addr(scan_x_q, scan_y_q, WIDTH);

  fb_bitmem #(
    .DEPTH (WIDTH * HEIGHT),
    .AW    (FB_ADDR_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_en_i    (op_req & op_in_range),
    .a_we_i    (op.op_ram_enable_write & op_in_range),
    .a_addr_i  (op_addr),
    .a_wdata_i (op.op_ram_write_value),
    .a_rdata_o (mem_a_rdata),
    .b_en_i    (scan_rd_en),
    .b_addr_i  (scan_addr),
    .b_rdata_o (mem_b_rdata)
  );

  // Out-of-range accesses leave the RAM read register alone; this flag masks it to 0
  // until the next in-range access, and holds along with it when the port is idle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_oob_rd_q <= 1'b0;
    end else if (op_req) begin
      op_oob_rd_q <= ~op_in_range;
    end
  end

  assign op.op_ram_value = mem_a_rdata & ~op_oob_rd_q;

  always_comb begin
    scan_x_d     = scan_x_q;
    scan_y_d     = scan_y_q;
    scan_valid_d = 1'b0;
    scan_done_d  = 1'b0;
    if (scan_restart) begin
      scan_x_d = '0;
      scan_y_d = '0;
    end else if (scan_en) begin
      scan_valid_d = 1'b1;
      if (scan_x_q == X_LAST) begin
        scan_x_d = '0;
        if (scan_y_q == Y_LAST) begin
          scan_y_d    = '0;
          scan_done_d = 1'b1;
        end else begin
          scan_y_d = scan_y_q + 1'b1;
        end
      end else begin
        scan_x_d = scan_x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      scan_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
    end else begin
      scan_x_q     <= scan_x_d;
      scan_y_q     <= scan_y_d;
      scan_valid_q <= scan_valid_d;
      scan_done_q  <= scan_done_d;
    end
  end

  // The port B register has no reset; gating keeps the pixel at 0 outside valid beats.
  assign scan_pixel      = mem_b_rdata & scan_valid_q;
  assign scan_valid      = scan_valid_q;
  assign scan_frame_done = scan_done_q;

`ifdef FB_BOUNDS_ERR_EN
  logic oob_error_q, oob_error_d;

  always_comb begin
    oob_error_d = oob_error_q;
    if (err_clear) begin
      oob_error_d = 1'b0;
    end
    if (op_req && !op_in_range) begin
      oob_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_error_q <= 1'b0;
    end else begin
      oob_error_q <= oob_error_d;
    end
  end

  assign oob_error = oob_error_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign oob_error        = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_framebuffer.sv
// Self-checking bench for gpu_framebuffer: op-port vector table plus scoreboarded scanout.
module tb_gpu_framebuffer;
  import gpu_defs::*;

`ifdef FB_BOUNDS_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  localparam int W = 320;
  localparam int H = 200;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scan_en = 1'b0;
  logic scan_restart = 1'b0;
  logic scan_pixel;
  logic scan_valid;
  logic scan_frame_done;
  logic err_clear = 1'b0;
  logic oob_error;

  gpu_framebuffer_if op_bus ();

  gpu_framebuffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .op              (op_bus),
    .scan_en         (scan_en),
    .scan_restart    (scan_restart),
    .scan_pixel      (scan_pixel),
    .scan_valid      (scan_valid),
    .scan_frame_done (scan_frame_done),
    .err_clear       (err_clear),
    .oob_error       (oob_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int sb_idx = 0;
  bit model [N];

  typedef struct {
    bit pix;
    bit done;
  } scan_exp_t;
  scan_exp_t sbq [$];

  typedef struct {
    bit rd;
    bit wr;
    int x;
    int y;
    bit wv;
    bit clr;
    bit chk;
    bit val;
    bit oob;
  } op_vec_t;
  op_vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_op(input bit rd, input bit wr, input int x, input int y,
                          input bit wv, input bit clr);
    op_bus.op_ram_enable_read  = rd;
    op_bus.op_ram_enable_write = wr;
    op_bus.op_x                = 9'(x);
    op_bus.op_y                = 8'(y);
    op_bus.op_ram_write_value  = wv;
    err_clear                  = clr;
    if (wr && x < W && y < H) model[y * W + x] = wv;
  endtask

  task automatic op_idle();
    drive_op(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // One scan cycle: drive, push expectation, then compare what the DUT shows after the edge.
  task automatic scan_step(input bit en, input bit restart);
    scan_exp_t e;
    scan_en      = en;
    scan_restart = restart;
    if (restart) begin
      sb_idx = 0;
    end else if (en) begin
      e.pix  = model[sb_idx];
      e.done = (sb_idx == N - 1);
      sbq.push_back(e);
      sb_idx = (sb_idx == N - 1) ? 0 : sb_idx + 1;
    end
    @(posedge clk);
    #1;
    if (scan_frame_done === 1'b1) done_seen++;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("scan_valid", int'(scan_valid), 1);
      check("scan_pixel", int'(scan_pixel), int'(e.pix));
      check("scan_frame_done", int'(scan_frame_done), int'(e.done));
    end else begin
      check("scan_valid_idle", int'(scan_valid), 0);
      check("scan_done_idle", int'(scan_frame_done), 0);
    end
    scan_en      = 1'b0;
    scan_restart = 1'b0;
  endtask

  initial begin
    op_bus.op_x = '0;
    op_bus.op_y = '0;
    op_bus.op_ram_enable_read = 1'b0;
    op_bus.op_ram_enable_write = 1'b0;
    op_bus.op_ram_write_value = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 1'b0;

    //     rd    wr    x    y    wv    clr   chk   val   oob
    vecs[0]  = '{1'b0, 1'b1,   5,   7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0,   5,   7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0,   6,   7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 320,   0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0,   0,   1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0,   0,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0,   5,   7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0,   0, 200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0,   0, 200, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0,   0,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1,   2,   2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0,   2,   2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0,   0,   0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    #2;
    check("rst_scan_valid", int'(scan_valid), 0);
    check("rst_scan_pixel", int'(scan_pixel), 0);
    check("rst_scan_done", int'(scan_frame_done), 0);
    check("rst_oob_error", int'(oob_error), 0);
    check("rst_op_value", int'(op_bus.op_ram_value), 0);
    $display("[TB] reset state checked");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rectangle (10..12, 3..4)
    for (int y = 3; y <= 4; y++) begin
      for (int x = 10; x <= 12; x++) begin
        drive_op(1'b0, 1'b1, x, y, 1'b1, 1'b0);
        @(posedge clk);
        #1;
      end
    end
    op_idle();
    $display("[TB] rectangle written");

    // Full frame after restart; frame_done only on the last pulse
    scan_step(1'b1, 1'b1);
    done_seen = 0;
    for (int i = 0; i < N; i++) scan_step(1'b1, 1'b0);
    check("frame_done_count", done_seen, 1);
    $display("[TB] full frame scanned, frame_done pulses=%0d", done_seen);

    // Wrap continues from (0,0); idle beats must show no valid
    for (int i = 0; i < 975; i++) scan_step(1'b1, 1'b0);
    scan_step(1'b0, 1'b0);
    scan_step(1'b0, 1'b0);
    $display("[TB] post-wrap scan checked");

    // Restart mid-line, scan_en held high alongside
    scan_step(1'b1, 1'b1);
    for (int i = 0; i < 975; i++) scan_step(1'b1, 1'b0);
    $display("[TB] mid-line restart checked");

    // Op port vector table
    for (int i = 0; i < 13; i++) begin
      drive_op(vecs[i].rd, vecs[i].wr, vecs[i].x, vecs[i].y, vecs[i].wv, vecs[i].clr);
      #7;
      if (vecs[i].chk) check($sformatf("op_value[%0d]", i), int'(op_bus.op_ram_value),
                             int'(vecs[i].val));
      @(posedge clk);
      #1;
      check($sformatf("oob_error[%0d]", i), int'(oob_error), int'(vecs[i].oob & ERR_ON));
      $display("[TB] op vec %0d rd=%0b wr=%0b (%0d,%0d) wv=%0b clr=%0b val=%0b oob=%0b",
               i, vecs[i].rd, vecs[i].wr, vecs[i].x, vecs[i].y, vecs[i].wv, vecs[i].clr,
               op_bus.op_ram_value, oob_error);
    end
    op_idle();

    // Async reset mid-frame
    scan_en = 1'b1;
    @(posedge clk);
    #2;
    check("pre_rst_valid", int'(scan_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(scan_valid), 0);
    check("async_rst_pixel", int'(scan_pixel), 0);
    check("async_rst_done", int'(scan_frame_done), 0);
    check("async_rst_op_value", int'(op_bus.op_ram_value), 0);
    check("async_rst_oob", int'(oob_error), 0);
    scan_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    sb_idx = 0;
    for (int i = 0; i < 1000; i++) scan_step(1'b1, 1'b0);
    $display("[TB] async reset checked, scan restarted at (0,0)");

    drive_op(1'b1, 1'b0, 5, 7, 1'b0, 1'b0);
    #7;
    check("post_rst_read_57", int'(op_bus.op_ram_value), 1);
    @(posedge clk);
    #1;
    op_idle();
    $display("[TB] memory retained across reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
